// File: rtl/mac_rx_pkg.sv
// Shared definitions for the MAC receive parser: FSM encoding, status bit
// positions, wire constants and the byte-wide CRC-32 step.
package mac_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_END,
    ST_DROP
  } state_e;

  // Bit positions inside m_status; bit 7 is reserved and always zero.
  localparam int STAT_PRE   = 0;
  localparam int STAT_RXER  = 1;
  localparam int STAT_DST   = 2;
  localparam int STAT_TYPE  = 3;
  localparam int STAT_FCS   = 4;
  localparam int STAT_RUNT  = 5;
  localparam int STAT_GIANT = 6;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [47:0] BCAST       = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  // One byte of CRC-32 (poly 04C11DB7) with the register held MSB-first and
  // each byte fed LSB-first, matching the bit order on the wire. Seeded with
  // all ones, the register ends at CRC_RESIDUE after a frame with good FCS.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? 32'h04C1_1DB7 : 32'h0000_0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_rx_parser_if.sv
// Output byte stream from the parser to the downstream frame buffer.
// Per-frame status and length qualify the m_last beat.
interface mac_rx_parser_if #(
  parameter int LEN_BITS = 14
);
  logic                m_valid;
  logic [7:0]          m_data;
  logic                m_last;
  logic                m_bad;
  logic [7:0]          m_status;
  logic [LEN_BITS-1:0] m_len;

  modport master (output m_valid, m_data, m_last, m_bad, m_status, m_len);
  modport slave  (input  m_valid, m_data, m_last, m_bad, m_status, m_len);
endinterface

// File: rtl/mac_addr_match.sv
// Destination address filter: unicast table lookup plus broadcast,
// multicast and promiscuous acceptance, reduced to a single accept bit.
module mac_addr_match
  import mac_rx_pkg::*;
#(
  parameter int NUM_MAC = 4
) (
  input  logic [47:0]          dst,
  input  logic [48*NUM_MAC-1:0] mac_tbl,
  input  logic [NUM_MAC-1:0]   mac_en,
  input  logic                 cfg_bcast_en,
  input  logic                 cfg_mcast_en,
  input  logic                 cfg_promisc,
  output logic                 accept
);

  logic uc_hit;

  // OR together the hits of every enabled unicast entry.
  always_comb begin
    // NOTE: default assignment first so every path writes uc_hit and no latch is inferred.
    uc_hit = 1'b0;
    for (int i = 0; i < NUM_MAC; i++) begin
      if (mac_en[i] && (mac_tbl[48*i +: 48] == dst)) begin
        uc_hit = 1'b1;
      end
    end
  end

  // dst[40] is the I/G bit: bit 0 of the first byte on the wire.
  assign accept = cfg_promisc
                | uc_hit
                | (cfg_bcast_en & (dst == BCAST))
                | (cfg_mcast_en & dst[40]);

endmodule

// File: rtl/mac_rx_parser.sv
// GMII receive parser: preamble/SFD hunt, address and EtherType filtering,
// FCS/runt/giant checks, optional FCS strip via a short hold pipeline, and
// per-frame status on the last emitted byte.
module mac_rx_parser
  import mac_rx_pkg::*;
#(
  parameter int NUM_MAC   = 4,
  parameter int STRIP_FCS = 1,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int LEN_BITS  = 14,
  parameter int MAX_PRE   = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_dv,
  input  logic                  rx_er,
  input  logic [7:0]            rx_d,
  input  logic [48*NUM_MAC-1:0] mac_tbl,
  input  logic [NUM_MAC-1:0]    mac_en,
  input  logic                  cfg_bcast_en,
  input  logic                  cfg_mcast_en,
  input  logic                  cfg_promisc,
  input  logic [15:0]           cfg_type,
  input  logic                  cfg_type_en,
  mac_rx_parser_if.master       m,
  output logic [31:0]           frm_good_cnt,
  output logic [31:0]           frm_bad_cnt
);

  // Hold depth: with stripping, the last four bytes (FCS) are held back and
  // never leave the pipeline.
  localparam int D = (STRIP_FCS != 0) ? 5 : 1;

  localparam logic [2:0]          D_L     = 3'(D);
  localparam logic [7:0]          PRE_L   = 8'(MAX_PRE);
  localparam logic [LEN_BITS-1:0] CNT_MAX = '1;
  localparam logic [LEN_BITS-1:0] CNT_D   = LEN_BITS'(D);
  localparam logic [LEN_BITS-1:0] MIN_L   = LEN_BITS'(MIN_FRAME);
  localparam logic [LEN_BITS-1:0] MAX_L   = LEN_BITS'(MAX_FRAME);
  localparam logic [LEN_BITS-1:0] FCS_L   = LEN_BITS'((STRIP_FCS != 0) ? 4 : 0);

  state_e              state;
  logic [7:0]          pre_cnt;
  logic [LEN_BITS-1:0] cnt;
  logic [31:0]         crc;
  logic [2:0]          fill;
  logic [7:0]          pipe [D];
  logic [39:0]         dst_sr;
  logic [7:0]          type_hi;
  logic                er_seen;
  logic                dst_miss;
  logic                type_miss;
  logic                addr_ok;
  logic [7:0]          status_c;

  // The address is evaluated on the sixth dst byte, using the five held
  // bytes plus the byte on the wire, so config is sampled exactly once.
  mac_addr_match #(.NUM_MAC(NUM_MAC)) u_addr_match (
    .dst          ({dst_sr, rx_d}),
    .mac_tbl      (mac_tbl),
    .mac_en       (mac_en),
    .cfg_bcast_en (cfg_bcast_en),
    .cfg_mcast_en (cfg_mcast_en),
    .cfg_promisc  (cfg_promisc),
    .accept       (addr_ok)
  );

  // Assemble the end-of-frame status word from the accumulated flags.
  always_comb begin
    status_c              = '0;
    status_c[STAT_RXER]   = er_seen;
    status_c[STAT_DST]    = dst_miss;
    status_c[STAT_TYPE]   = type_miss;
    status_c[STAT_FCS]    = (crc != CRC_RESIDUE);
    status_c[STAT_RUNT]   = (cnt < MIN_L);
    status_c[STAT_GIANT]  = (cnt > MAX_L);
  end

  // Frame FSM with hold pipeline, filters, registered stream outputs and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      pre_cnt      <= '0;
      cnt          <= '0;
      crc          <= '1;
      fill         <= '0;
      // NOTE: the hold pipeline is reset too so a reset mid-frame can never leak stale bytes.
      for (int i = 0; i < D; i++) pipe[i] <= '0;
      dst_sr       <= '0;
      type_hi      <= '0;
      er_seen      <= 1'b0;
      dst_miss     <= 1'b0;
      type_miss    <= 1'b0;
      m.m_valid    <= 1'b0;
      m.m_data     <= '0;
      m.m_last     <= 1'b0;
      m.m_bad      <= 1'b0;
      m.m_status   <= '0;
      m.m_len      <= '0;
      frm_good_cnt <= '0;
      frm_bad_cnt  <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      m.m_valid  <= 1'b0;
      m.m_last   <= 1'b0;
      m.m_bad    <= 1'b0;
      m.m_status <= '0;
      m.m_len    <= '0;

      case (state)
        ST_IDLE: begin
          if (rx_dv) begin
            if (rx_d == PREAMBLE) begin
              state   <= ST_PRE;
              pre_cnt <= 8'd1;
            end else begin
              state <= ST_DROP;
            end
          end
        end

        ST_PRE: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end else if (rx_er) begin
            state <= ST_DROP;
          end else if ((rx_d == PREAMBLE) && (pre_cnt < PRE_L)) begin
            pre_cnt <= pre_cnt + 8'd1;
          end else if (rx_d == SFD) begin
            state     <= ST_DATA;
            cnt       <= '0;
            crc       <= '1;
            fill      <= '0;
            er_seen   <= 1'b0;
            dst_miss  <= 1'b0;
            type_miss <= 1'b0;
          end else begin
            state <= ST_DROP;
          end
        end

        ST_DATA: begin
          if (!rx_dv) begin
            state <= ST_END;
          end else begin
            crc <= crc32_d8(crc, rx_d);
            if (cnt != CNT_MAX) cnt <= cnt + LEN_BITS'(1);
            if (rx_er) er_seen <= 1'b1;

            if (cnt < LEN_BITS'(5))  dst_sr    <= {dst_sr[31:0], rx_d};
            if (cnt == LEN_BITS'(5)) dst_miss  <= !addr_ok;
            if (cnt == LEN_BITS'(12)) type_hi  <= rx_d;
            if (cnt == LEN_BITS'(13)) type_miss <= cfg_type_en && ({type_hi, rx_d} != cfg_type);

            // Push the new byte; once the pipeline is full the oldest byte leaves.
            pipe[0] <= rx_d;
            for (int i = D - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            if (fill == D_L) begin
              m.m_valid <= 1'b1;
              m.m_data  <= pipe[D-1];
            end else begin
              fill <= fill + 3'd1;
            end
          end
        end

        ST_END: begin
          state <= ST_IDLE;
          // Frames that never pushed a byte out of the pipeline emit nothing.
          if (cnt > CNT_D) begin
            m.m_valid  <= 1'b1;
            m.m_data   <= pipe[D-1];
            m.m_last   <= 1'b1;
            m.m_bad    <= |status_c;
            m.m_status <= status_c;
            m.m_len    <= cnt - FCS_L;
            if (|status_c) frm_bad_cnt  <= frm_bad_cnt + 32'd1;
            else           frm_good_cnt <= frm_good_cnt + 32'd1;
          end else begin
            frm_bad_cnt <= frm_bad_cnt + 32'd1;
          end
        end

        ST_DROP: begin
          if (!rx_dv) begin
            state       <= ST_IDLE;
            frm_bad_cnt <= frm_bad_cnt + 32'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_parser.sv
// Directed bench for mac_rx_parser with default parameters (FCS stripped).
module tb_mac_rx_parser;

  localparam int NUM_MAC = 4;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  rx_dv = 1'b0;
  logic                  rx_er = 1'b0;
  logic [7:0]            rx_d = 8'h00;
  logic [48*NUM_MAC-1:0] mac_tbl;
  logic [NUM_MAC-1:0]    mac_en;
  logic                  cfg_bcast_en;
  logic                  cfg_mcast_en;
  logic                  cfg_promisc;
  logic [15:0]           cfg_type;
  logic                  cfg_type_en;
  logic [31:0]           good_cnt;
  logic [31:0]           bad_cnt;

  mac_rx_parser_if #(.LEN_BITS(14)) m_if ();

  mac_rx_parser #(
    .NUM_MAC(NUM_MAC), .STRIP_FCS(1), .MIN_FRAME(64),
    .MAX_FRAME(1518), .LEN_BITS(14), .MAX_PRE(7)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_dv        (rx_dv),
    .rx_er        (rx_er),
    .rx_d         (rx_d),
    .mac_tbl      (mac_tbl),
    .mac_en       (mac_en),
    .cfg_bcast_en (cfg_bcast_en),
    .cfg_mcast_en (cfg_mcast_en),
    .cfg_promisc  (cfg_promisc),
    .cfg_type     (cfg_type),
    .cfg_type_en  (cfg_type_en),
    .m            (m_if),
    .frm_good_cnt (good_cnt),
    .frm_bad_cnt  (bad_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_good = 0;
  int exp_bad = 0;

  logic [7:0]  frm_q [$];
  logic [7:0]  rx_q [$];
  int          last_seen;
  logic [7:0]  last_status;
  logic        last_bad;
  logic [13:0] last_len;

  localparam logic [47:0] MAC0   = 48'h0211_2233_4455;
  localparam logic [47:0] MAC2   = 48'h02AA_BBCC_DDEE;
  localparam logic [47:0] MCAST  = 48'h0100_5E00_0001;
  localparam logic [47:0] BC     = 48'hFFFF_FFFF_FFFF;

  // Collect emitted bytes and the end-of-frame qualifiers.
  always @(negedge clk) begin
    if (m_if.m_valid) begin
      rx_q.push_back(m_if.m_data);
      if (m_if.m_last) begin
        last_seen++;
        last_status = m_if.m_status;
        last_bad    = m_if.m_bad;
        last_len    = m_if.m_len;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference Ethernet FCS: reflected CRC-32, complemented.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Builds dst, fixed src, type, patterned payload and FCS; len includes FCS.
  task automatic make_frame(input logic [47:0] dst, input logic [15:0] etype, input int len);
    logic [31:0] f;
    frm_q.delete();
    for (int i = 0; i < 6; i++) frm_q.push_back(dst[47-8*i -: 8]);
    frm_q.push_back(8'h02);
    for (int i = 0; i < 4; i++) frm_q.push_back(8'h00);
    frm_q.push_back(8'h01);
    frm_q.push_back(etype[15:8]);
    frm_q.push_back(etype[7:0]);
    while (frm_q.size() < len - 4) frm_q.push_back(8'(frm_q.size() * 7 + 3));
    f = fcs_of(len - 4);
    for (int i = 0; i < 4; i++) frm_q.push_back(f[8*i +: 8]);
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    rx_dv = dv;
    rx_er = er;
    rx_d  = d;
  endtask

  // Preamble, start byte, then up to 'limit' frame bytes; dv drops after a full frame.
  task automatic send(input int pre, input logic [7:0] sfd, input int er_at, input int limit);
    for (int i = 0; i < pre; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, sfd);
    for (int i = 0; i < frm_q.size() && i < limit; i++) drive(1'b1, (i == er_at), frm_q[i]);
    if (limit >= frm_q.size()) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    last_seen = 0;
    last_status = 8'hxx;
    last_len = 'x;
    last_bad = 1'bx;
  endtask

  task automatic run(input int pre, input int er_at);
    clear_mon();
    send(pre, 8'hD5, er_at, 1 << 30);
    repeat (12) @(negedge clk);
  endtask

  // Compare one completed frame against its expected status and length.
  task automatic check_frame(input string tag, input logic [7:0] st, input int len);
    int errs;
    errs = 0;
    for (int i = 0; i < rx_q.size(); i++) if (i < frm_q.size() && rx_q[i] !== frm_q[i]) errs++;
    if (st == 8'h00) exp_good++; else exp_bad++;
    check({tag, ".last"},   32'(last_seen), 32'd1);
    check({tag, ".status"}, last_status, st);
    check({tag, ".bad"},    last_bad, (st != 8'h00));
    check({tag, ".len"},    last_len, 14'(len));
    check({tag, ".nbytes"}, 32'(rx_q.size()), 32'(len));
    check({tag, ".data"},   32'(errs), 32'd0);
    check({tag, ".good"},   good_cnt, 32'(exp_good));
    check({tag, ".badcnt"}, bad_cnt, 32'(exp_bad));
  endtask

  task automatic check_drop(input string tag);
    exp_bad++;
    check({tag, ".nbytes"}, 32'(rx_q.size()), 32'd0);
    check({tag, ".last"},   32'(last_seen), 32'd0);
    check({tag, ".badcnt"}, bad_cnt, 32'(exp_bad));
  endtask

  initial begin
    mac_tbl      = {48'h0, MAC2, 48'h0211_2233_4466, MAC0};
    mac_en       = 4'b0011;
    cfg_bcast_en = 1'b1;
    cfg_mcast_en = 1'b0;
    cfg_promisc  = 1'b0;
    cfg_type     = 16'hAA55;
    cfg_type_en  = 1'b1;
    clear_mon();

    repeat (3) @(negedge clk);
    check("rst.valid", m_if.m_valid, 1'b0);
    check("rst.last",  m_if.m_last, 1'b0);
    check("rst.good",  good_cnt, 32'd0);
    check("rst.bad",   bad_cnt, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    make_frame(MAC0, 16'hAA55, 64);
    run(7, -1);
    check_frame("good64", 8'h00, 60);

    make_frame(MAC0, 16'hAA55, 64);
    frm_q[20] = frm_q[20] ^ 8'h01;
    run(7, -1);
    check_frame("fcs_err", 8'h10, 60);

    cfg_bcast_en = 1'b0;
    make_frame(BC, 16'hAA55, 64);
    run(7, -1);
    check_frame("bcast_off", 8'h04, 60);
    cfg_bcast_en = 1'b1;
    run(7, -1);
    check_frame("bcast_on", 8'h00, 60);

    cfg_mcast_en = 1'b1;
    make_frame(MCAST, 16'hAA55, 64);
    run(7, -1);
    check_frame("mcast", 8'h00, 60);
    cfg_mcast_en = 1'b0;

    make_frame(MAC2, 16'hAA55, 64);
    run(7, -1);
    check_frame("disabled_entry", 8'h04, 60);
    cfg_promisc = 1'b1;
    run(7, -1);
    check_frame("promisc", 8'h00, 60);
    cfg_promisc = 1'b0;

    make_frame(MAC0, 16'hAA55, 64);
    run(3, -1);
    check_frame("pre3", 8'h00, 60);

    run(8, -1);
    check_drop("pre8");

    clear_mon();
    send(2, 8'hA5, -1, 1 << 30);
    repeat (12) @(negedge clk);
    check_drop("bad_sfd");

    make_frame(MAC0, 16'hAA55, 40);
    run(7, -1);
    check_frame("runt", 8'h20, 36);

    make_frame(MAC0, 16'hAA55, 1600);
    run(7, -1);
    check_frame("giant", 8'h40, 1596);

    make_frame(MAC0, 16'hAA55, 64);
    run(7, 30);
    check_frame("rx_er", 8'h02, 60);

    make_frame(MAC0, 16'h0800, 64);
    run(7, -1);
    check_frame("type_miss", 8'h08, 60);

    // Two frames separated by a single dv-low cycle.
    make_frame(MAC0, 16'hAA55, 64);
    clear_mon();
    send(7, 8'hD5, -1, 1 << 30);
    send(7, 8'hD5, -1, 1 << 30);
    repeat (12) @(negedge clk);
    begin
      int errs;
      errs = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== frm_q[i % 60]) errs++;
      exp_good += 2;
      check("b2b.last",   32'(last_seen), 32'd2);
      check("b2b.nbytes", 32'(rx_q.size()), 32'd120);
      check("b2b.data",   32'(errs), 32'd0);
      check("b2b.status", last_status, 8'h00);
      check("b2b.good",   good_cnt, 32'(exp_good));
    end

    // Reset in the middle of the payload.
    clear_mon();
    send(7, 8'hD5, -1, 30);
    @(negedge clk);
    check("midrst.pre_valid", m_if.m_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst.valid", m_if.m_valid, 1'b0);
    rx_dv = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst.last", 32'(last_seen), 32'd0);
    check("midrst.good", good_cnt, 32'd0);
    check("midrst.bad",  bad_cnt, 32'd0);

    // Parser must be usable straight after the mid-frame reset.
    exp_good = 0;
    exp_bad = 0;
    make_frame(MAC0, 16'hAA55, 64);
    run(7, -1);
    check_frame("post_rst", 8'h00, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
